// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch-side PC controller: FSM encodings,
// PC step size and the default reset address.
package fetch_pkg;

    typedef enum logic [1:0] {
        FS_RUN    = 2'b00,
        FS_BUBBLE = 2'b01,
        FS_HALT   = 2'b10
    } fetch_state_e;

    localparam logic [15:0] PC_STEP          = 16'd2;
    localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

    // Instructions are halfword aligned, so bit 0 of any target is dropped.
    function automatic logic [15:0] align_pc(input logic [15:0] addr);
        return {addr[15:1], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_pc_ctrl_if.sv
// Handshake bundle between decode/execute and the fetch PC controller.
// The controller sits on the slave side; the pipeline drives the master side.
interface fetch_pc_ctrl_if #(
    parameter int N = 16
);
    logic         stall;
    logic         redirect_valid;
    logic [N-1:0] redirect_pc;
    logic         halt;
    logic [N-1:0] pc_out;
    logic [N-1:0] pc_inc;
    logic         fetch_valid;
    logic         flush_if;
    logic         halted;
    logic         misalign_err;

    modport master (
        output stall, redirect_valid, redirect_pc, halt,
        input  pc_out, pc_inc, fetch_valid, flush_if, halted, misalign_err
    );

    modport slave (
        input  stall, redirect_valid, redirect_pc, halt,
        output pc_out, pc_inc, fetch_valid, flush_if, halted, misalign_err
    );
endinterface

// File: rtl/cla_16b.sv
// 16-bit carry-lookahead adder: four 4-bit lookahead groups with the group
// carries chained through group generate/propagate terms.
module cla_16b (
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        C_in,
    output logic [15:0] S,
    output logic        C_out
);
    logic [15:0] p;
    logic [15:0] g;
    logic [15:0] c;
    logic [3:0]  grp_p;
    logic [3:0]  grp_g;
    logic [4:0]  grp_c;

    assign p        = A ^ B;
    assign g        = A & B;
    assign grp_c[0] = C_in;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_group
            logic [3:0] gp;
            logic [3:0] gg;
            logic       ci;

            assign gp = p[4*gi +: 4];
            assign gg = g[4*gi +: 4];
            assign ci = grp_c[gi];

            assign c[4*gi]     = ci;
            assign c[4*gi + 1] = gg[0] | (gp[0] & ci);
            assign c[4*gi + 2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & ci);
            assign c[4*gi + 3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                               | (gp[2] & gp[1] & gp[0] & ci);

            assign grp_p[gi] = &gp;
            assign grp_g[gi] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
                             | (gp[3] & gp[2] & gp[1] & gg[0]);
            assign grp_c[gi + 1] = grp_g[gi] | (grp_p[gi] & grp_c[gi]);
        end
    endgenerate

    assign S     = p ^ c;
    assign C_out = grp_c[4];
endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch PC generator: holds the architectural PC, applies stalls, takes
// branch/jump redirects with a fixed bubble window, and freezes on HALT.
module fetch_pc_ctrl
    import fetch_pkg::*;
#(
    parameter int           N                = 16,
    parameter logic [N-1:0] RESET_PC         = DEFAULT_RESET_PC,
    parameter int           REDIRECT_BUBBLES = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    fetch_pc_ctrl_if.slave bus
);
    localparam logic [2:0] CNT_LOAD = 3'(REDIRECT_BUBBLES - 1);

    fetch_state_e state_reg, state_next;
    logic [N-1:0] pc_reg, pc_next;
    logic [2:0]   cnt_reg, cnt_next;
    logic         mis_reg, mis_next;
    logic [N-1:0] pc_inc_sum;
    logic         inc_carry_unused;

    cla_16b u_pc_inc (
        .A     (pc_reg),
        .B     (PC_STEP),
        .C_in  (1'b0),
        .S     (pc_inc_sum),
        .C_out (inc_carry_unused)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= FS_RUN;
            pc_reg    <= RESET_PC;
            cnt_reg   <= 3'd0;
            mis_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            cnt_reg   <= cnt_next;
            mis_reg   <= mis_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        cnt_next   = cnt_reg;
        // A redirect is only accepted outside HALT, so only then can it flag misalignment.
        mis_next   = mis_reg | (bus.redirect_valid & bus.redirect_pc[0] & (state_reg != FS_HALT));

        case (state_reg)
            FS_RUN: begin
                if (bus.redirect_valid) begin
                    pc_next    = align_pc(bus.redirect_pc);
                    cnt_next   = CNT_LOAD;
                    state_next = FS_BUBBLE;
                end else if (bus.halt) begin
                    state_next = FS_HALT;
                end else if (!bus.stall) begin
                    pc_next = pc_inc_sum;
                end
            end
            FS_BUBBLE: begin
                // Halt here comes from the wrong path; stall does not stretch the window.
                if (bus.redirect_valid) begin
                    pc_next  = align_pc(bus.redirect_pc);
                    cnt_next = CNT_LOAD;
                end else if (cnt_reg == 3'd0) begin
                    state_next = FS_RUN;
                end else begin
                    cnt_next = cnt_reg - 3'd1;
                end
            end
            FS_HALT: begin
                state_next = FS_HALT;
            end
            default: begin
                state_next = FS_RUN;
            end
        endcase
    end

    assign bus.pc_out       = pc_reg;
    assign bus.pc_inc       = pc_inc_sum;
    assign bus.fetch_valid  = (state_reg == FS_RUN) & ~bus.stall & rst_n;
    assign bus.flush_if     = bus.redirect_valid & (state_reg != FS_HALT) & rst_n;
    assign bus.halted       = (state_reg == FS_HALT);
    assign bus.misalign_err = mis_reg;
endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Drives two controllers (1 and 3 redirect bubbles) with identical stimulus and
// compares both against a cycle-level model of the fetch rules.
module tb_fetch_pc_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        halt;

    int total = 0;
    int bad   = 0;

    // Model state per instance: index 0 -> 1 bubble, index 1 -> 3 bubbles.
    int m_pc[2];
    int m_left[2];
    bit m_halt[2];
    bit m_mis[2];

    always #5 clk = ~clk;

    fetch_pc_ctrl_if #(.N(16)) bus1 ();
    fetch_pc_ctrl_if #(.N(16)) bus3 ();

    assign bus1.stall          = stall;
    assign bus1.redirect_valid = redirect_valid;
    assign bus1.redirect_pc    = redirect_pc;
    assign bus1.halt           = halt;
    assign bus3.stall          = stall;
    assign bus3.redirect_valid = redirect_valid;
    assign bus3.redirect_pc    = redirect_pc;
    assign bus3.halt           = halt;

    fetch_pc_ctrl #(.N(16), .RESET_PC(16'h0000), .REDIRECT_BUBBLES(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    fetch_pc_ctrl #(.N(16), .RESET_PC(16'h0000), .REDIRECT_BUBBLES(3)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3)
    );

    function automatic int bubbles(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pc[k]   = 0;
            m_left[k] = 0;
            m_halt[k] = 1'b0;
            m_mis[k]  = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (m_halt[k]) begin
                // frozen until reset
            end else if (redirect_valid) begin
                m_pc[k]   = int'(redirect_pc) & 16'hFFFE;
                m_left[k] = bubbles(k);
                if (redirect_pc[0]) m_mis[k] = 1'b1;
            end else if (m_left[k] > 0) begin
                m_left[k] = m_left[k] - 1;
            end else if (halt) begin
                m_halt[k] = 1'b1;
            end else if (!stall) begin
                m_pc[k] = (m_pc[k] + 2) % 65536;
            end
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            logic [15:0] pc_o, inc_o;
            logic        fv_o, fl_o, h_o, me_o;
            logic        fv_e, fl_e;
            pc_o  = (k == 0) ? bus1.pc_out       : bus3.pc_out;
            inc_o = (k == 0) ? bus1.pc_inc       : bus3.pc_inc;
            fv_o  = (k == 0) ? bus1.fetch_valid  : bus3.fetch_valid;
            fl_o  = (k == 0) ? bus1.flush_if     : bus3.flush_if;
            h_o   = (k == 0) ? bus1.halted       : bus3.halted;
            me_o  = (k == 0) ? bus1.misalign_err : bus3.misalign_err;
            fv_e  = rst_n && !m_halt[k] && (m_left[k] == 0) && !stall;
            fl_e  = rst_n && redirect_valid && !m_halt[k];
            check($sformatf("pc_out[b%0d]", bubbles(k)), pc_o, 16'(m_pc[k]));
            check($sformatf("pc_inc[b%0d]", bubbles(k)), inc_o, 16'((m_pc[k] + 2) % 65536));
            check($sformatf("fetch_valid[b%0d]", bubbles(k)), {15'd0, fv_o}, {15'd0, fv_e});
            check($sformatf("flush_if[b%0d]", bubbles(k)), {15'd0, fl_o}, {15'd0, fl_e});
            check($sformatf("halted[b%0d]", bubbles(k)), {15'd0, h_o}, {15'd0, m_halt[k]});
            check($sformatf("misalign_err[b%0d]", bubbles(k)), {15'd0, me_o}, {15'd0, m_mis[k]});
        end
    endtask

    // Check outputs mid-cycle, then advance one clock; returns 1 ns after the edge.
    task automatic tick();
        @(negedge clk);
        check_all();
        $display("t=%0t rst_n=%b stall=%b rv=%b rpc=%h halt=%b | pc1=%h v1=%b pc3=%h v3=%b",
                 $time, rst_n, stall, redirect_valid, redirect_pc, halt,
                 bus1.pc_out, bus1.fetch_valid, bus3.pc_out, bus3.fetch_valid);
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    task automatic set_in(input logic s, input logic rv, input logic [15:0] rpc, input logic h);
        stall          = s;
        redirect_valid = rv;
        redirect_pc    = rpc;
        halt           = h;
    endtask

    // Asynchronous reset asserted mid-cycle, held for two edges.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(1'b0, 1'b0, 16'h0000, 1'b0);
        model_reset();
        #1;
        check_all();
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check("first_fetch_pc", bus1.pc_out, 16'h0000);
        check("first_fetch_valid", {15'd0, bus1.fetch_valid}, 16'd1);

        // Free run 0000..0006, then redirect to 0040
        tick(); tick(); tick();
        check("run_pc_0006", bus1.pc_out, 16'h0006);
        set_in(1'b0, 1'b1, 16'h0040, 1'b0);
        tick();
        set_in(1'b0, 1'b0, 16'h0000, 1'b0);
        check("redirect_0040", bus1.pc_out, 16'h0040);
        tick(); tick(); tick(); tick();

        // Stall at 0010, then redirect during stall
        set_in(1'b0, 1'b1, 16'h0010, 1'b0);
        tick();
        set_in(1'b0, 1'b0, 16'h0000, 1'b0);
        tick();
        set_in(1'b1, 1'b0, 16'h0000, 1'b0);
        tick(); tick(); tick();
        check("stall_hold_0010", bus1.pc_out, 16'h0010);
        set_in(1'b0, 1'b0, 16'h0000, 1'b0);
        tick(); tick();
        set_in(1'b1, 1'b1, 16'h0080, 1'b0);
        tick();
        check("stall_redirect_0080", bus1.pc_out, 16'h0080);
        set_in(1'b0, 1'b0, 16'h0000, 1'b0);
        tick(); tick(); tick(); tick(); tick();

        // Halt together with redirect: redirect wins; later halt at 0104
        set_in(1'b0, 1'b1, 16'h0100, 1'b1);
        tick();
        set_in(1'b0, 1'b0, 16'h0000, 1'b0);
        tick(); tick(); tick();
        check("pre_halt_0104", bus1.pc_out, 16'h0104);
        set_in(1'b0, 1'b0, 16'h0000, 1'b1);
        tick();
        check("halted_set", {15'd0, bus1.halted}, 16'd1);
        set_in(1'b0, 1'b1, 16'h0200, 1'b0);
        tick(); tick();
        set_in(1'b1, 1'b0, 16'h0000, 1'b1);
        tick();
        check("halt_frozen_0104", bus1.pc_out, 16'h0104);
        set_in(1'b0, 1'b0, 16'h0000, 1'b0);
        do_reset();

        // Misaligned target, then wrap-around from FFFE
        tick();
        set_in(1'b0, 1'b1, 16'h0031, 1'b0);
        tick();
        check("misalign_pc_0030", bus1.pc_out, 16'h0030);
        set_in(1'b0, 1'b0, 16'h0000, 1'b0);
        tick(); tick(); tick();
        set_in(1'b0, 1'b1, 16'hFFFE, 1'b0);
        tick();
        set_in(1'b0, 1'b0, 16'h0000, 1'b0);
        tick(); tick(); tick(); tick(); tick();

        // Back-to-back redirects during the bubble window
        set_in(1'b0, 1'b1, 16'h0100, 1'b0);
        tick();
        set_in(1'b0, 1'b1, 16'h0200, 1'b0);
        tick();
        check("second_redirect_0200", bus3.pc_out, 16'h0200);
        set_in(1'b0, 1'b0, 16'h0000, 1'b0);
        tick(); tick(); tick(); tick(); tick(); tick();

        // Reset in the middle of a bubble window
        set_in(1'b0, 1'b1, 16'h0300, 1'b0);
        tick();
        set_in(1'b0, 1'b0, 16'h0000, 1'b0);
        do_reset();
        tick();

        // Randomised traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            set_in(($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 7) == 0),
                   16'($urandom),
                   ($urandom_range(0, 31) == 0));
            if ($urandom_range(0, 99) == 0) do_reset();
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_pc_ctrl.md
Name: fetch_pc_ctrl

Overview:
- Fetch-side PC generator; consumes the branch/jump target (b_j_PC) from execute as a redirect and drives the instruction-memory fetch address.
- Holds the architectural PC, produces PC+2 (fed back to execute as the PC/link operand), and applies hazard stalls.
- Inserts post-redirect bubbles, squashes the wrong-path IF/ID instruction and handles HALT.

Parameters:
N, 16, datapath/address width
RESET_PC, 16'h0000, PC value loaded on reset
REDIRECT_BUBBLES, 1, fetch-invalid cycles inserted after each redirect (legal 1..7)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
stall  input  1  hazard stall from decode; hold PC
redirect_valid  input  1  execute resolved a taken branch/jump this cycle
redirect_pc  input  N  target address (b_j_PC)
halt  input  1  HALT decoded in IF/ID
pc_out  output  N  current fetch address
pc_inc  output  N  pc_out + 2, modulo 2^N
fetch_valid  output  1  pc_out is a valid fetch this cycle
flush_if  output  1  squash instruction currently in IF/ID
halted  output  1  core halted
misalign_err  output  1  sticky: an odd redirect target was received

Behaviour:
- Clock/reset: one clock clk. Reset rst_n is asynchronous, active-low; all flops clear immediately on rst_n falling, independent of clk.
- Reset values: pc_out=RESET_PC, pc_inc=RESET_PC+2, state=RUN, bubble counter=0, halted=0, misalign_err=0. fetch_valid=0 and flush_if=0 while rst_n low.
- First valid fetch is RESET_PC, in the first cycle after rst_n deasserts.
- States: RUN, BUBBLE, HALT (2-bit encoding).
- Combinational outputs:
  - fetch_valid = (state==RUN) & ~stall & rst_n
  - flush_if = redirect_valid & (state!=HALT)
  - halted = (state==HALT)
- RUN transitions, in priority order:
  1. redirect_valid: pc <= {redirect_pc[N-1:1],1'b0}; cnt <= REDIRECT_BUBBLES-1; -> BUBBLE.
  2. halt: pc held; -> HALT.
  3. stall: pc held; stay RUN.
  4. Otherwise: pc <= pc_inc.
- BUBBLE state:
  - fetch_valid=0; halt is ignored (it belongs to the wrong path).
  - redirect_valid reloads pc and cnt and stays in BUBBLE (latest redirect wins).
  - Otherwise cnt decrements every cycle regardless of stall; cnt==0 -> RUN with pc unchanged.
  - Net effect: the redirect target is first presented valid exactly REDIRECT_BUBBLES+1 cycles after the redirect edge, provided stall is low.
- HALT state: pc frozen, fetch_valid=0; all inputs ignored; exit only via reset.
- Redirect and halt in the same cycle: redirect wins. The halt is younger and on the wrong path.
- Redirect and stall in the same cycle: redirect wins. The stalled instruction is squashed via flush_if.
- Misalignment: redirect_pc[0]=1 sets misalign_err (sticky until reset); bit 0 is cleared before loading.
- Wrap-around: pc_inc at 16'hFFFE = 16'h0000; no carry or overflow is reported.
- Reset mid-BUBBLE or mid-HALT returns to RUN at RESET_PC; any pending bubbles are discarded.
- Latency: redirect_pc is sampled at the edge ending the redirect_valid cycle and appears on pc_out the following cycle.
- pc_out is a registered output. pc_inc is combinational from pc_out.

Decomposition:
- Shared package fetch_pkg holds:
  - state encodings FS_RUN=2'b00, FS_BUBBLE=2'b01, FS_HALT=2'b10
  - PC_STEP=16'd2
  - default RESET_PC
- Sub-module: instance of the existing cla_16b adder as the PC+2 incrementer: A=pc_out, B=PC_STEP, C_in=0, C_out unused.
- The FSM and PC register stay inside fetch_pc_ctrl.

Test Plan:
- Reset then free-run, stall=0 -> pc_out sequence 0000,0002,0004,0006; fetch_valid=1 from the first post-reset cycle; pc_inc always pc_out+2.
- redirect_valid=1 with redirect_pc=16'h0040 at pc=0006, REDIRECT_BUBBLES=1 -> flush_if=1 that cycle; next cycle pc_out=0040 with fetch_valid=0; following cycle fetch_valid=1; then 0042.
- stall=1 for 3 cycles at pc=0010 -> pc_out held at 0010 with fetch_valid=0; resumes 0012 after release. Redirect to 0080 during stall -> pc_out=0080, stall overridden.
- halt=1 together with redirect_valid to 0100 -> no halt, pc_out=0100. Later halt alone at 0104 -> halted=1, pc frozen at 0104 despite redirects; rst_n low -> pc_out=0000, halted=0.
- Redirect to 16'h0031 -> pc_out=0030, misalign_err=1 and stays 1. Redirect to FFFE then run -> pc_out FFFE then 0000.
- Second redirect to 0200 during BUBBLE from a first redirect to 0100 (REDIRECT_BUBBLES=3) -> pc_out=0200; bubble count restarts; first valid fetch is 0200, 4 cycles after the second redirect.
